// File: rtl/add_seq_ctrl_if.sv
// +--------------------------------------------------------------------------+
// | add_seq_ctrl_if : operand/result handshake bundle for add_seq_ctrl.      |
// | Optional ovf signal present with ADD_SEQ_OVF_EN.  Rev 1.0                |
// +--------------------------------------------------------------------------+
`default_nettype none

interface add_seq_ctrl_if #(
   parameter int WORDS = 4
);
   logic                 start;
   logic                 op;
   logic [8*WORDS-1:0]   a;
   logic [8*WORDS-1:0]   b;
   logic                 cin;
   logic                 busy;
   logic                 done;
   logic [8*WORDS-1:0]   result;
   logic                 cout;
`ifdef ADD_SEQ_OVF_EN
   logic                 ovf;

   modport master (
      output start, op, a, b, cin,
      input  busy, done, result, cout, ovf
   );
   modport slave (
      input  start, op, a, b, cin,
      output busy, done, result, cout, ovf
   );
`else
   modport master (
      output start, op, a, b, cin,
      input  busy, done, result, cout
   );
   modport slave (
      input  start, op, a, b, cin,
      output busy, done, result, cout
   );
`endif
endinterface

`default_nettype wire

// File: rtl/add_seq_ctrl.sv
// +--------------------------------------------------------------------------+
// | add_seq_ctrl : byte-serial wide add/subtract through one 8-bit CLA.      |
// | Define ADD_SEQ_OVF_EN to add the signed-overflow output.  Rev 1.0        |
// +--------------------------------------------------------------------------+
`default_nettype none

module add_8 (
   input  wire logic [7:0] a_i,
   input  wire logic [7:0] b_i,
   input  wire logic       ci_i,
   output logic      [7:0] s_o,
   output logic            co_o
);
   logic [7:0] w_g;
   logic [7:0] w_p;
   logic [8:0] w_c;

   assign w_g = a_i & b_i;
   assign w_p = a_i ^ b_i;

   // Each carry is a flat sum of products of lower generates/propagates.
   always_comb begin
      logic w_term;
      logic w_prop;
      w_c    = '0;
      w_c[0] = ci_i;
      for (int i = 0; i < 8; i++) begin
         w_term = w_g[i];
         w_prop = w_p[i];
         for (int j = 6; j >= 0; j--) begin
            if (j < i) begin
               w_term = w_term | (w_prop & w_g[j]);
               w_prop = w_prop & w_p[j];
            end
         end
         w_c[i+1] = w_term | (w_prop & ci_i);
      end
   end

   assign s_o  = w_p ^ w_c[7:0];
   assign co_o = w_c[8];
endmodule

module add_seq_ctrl #(
   parameter int WORDS = 4
) (
   input  wire logic      clk,
   input  wire logic      rst_n,
   add_seq_ctrl_if.slave  bus
);
   localparam int W  = 8 * WORDS;
   localparam int IW = $clog2(WORDS);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t            state_q,  state_d;
   logic [W-1:0]      a_q,      a_d;
   logic [W-1:0]      b_q,      b_d;
   logic [W-1:0]      acc_q,    acc_d;
   logic [W-1:0]      result_q, result_d;
   logic              carry_q,  carry_d;
   logic              cout_q,   cout_d;
   logic [IW-1:0]     idx_q,    idx_d;
`ifdef ADD_SEQ_OVF_EN
   logic              ovf_q,    ovf_d;
`endif

   logic [IW+2:0]     w_base;
   logic [7:0]        w_add_a;
   logic [7:0]        w_add_b;
   logic [7:0]        w_sum;
   logic              w_co;

   assign w_base  = {idx_q, 3'b000};
   assign w_add_a = a_q[w_base +: 8];
   assign w_add_b = b_q[w_base +: 8];

   add_8 u_add_8 (
      .a_i  (w_add_a),
      .b_i  (w_add_b),
      .ci_i (carry_q),
      .s_o  (w_sum),
      .co_o (w_co)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         a_q      <= '0;
         b_q      <= '0;
         acc_q    <= '0;
         result_q <= '0;
         carry_q  <= 1'b0;
         cout_q   <= 1'b0;
         idx_q    <= '0;
`ifdef ADD_SEQ_OVF_EN
         ovf_q    <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         acc_q    <= acc_d;
         result_q <= result_d;
         carry_q  <= carry_d;
         cout_q   <= cout_d;
         idx_q    <= idx_d;
`ifdef ADD_SEQ_OVF_EN
         ovf_q    <= ovf_d;
`endif
      end
   end

   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      acc_d    = acc_q;
      result_d = result_q;
      carry_d  = carry_q;
      cout_d   = cout_q;
      idx_d    = idx_q;
`ifdef ADD_SEQ_OVF_EN
      ovf_d    = ovf_q;
`endif
      case (state_q)
         S_IDLE, S_DONE: begin
            state_d = S_IDLE;
            if (bus.start) begin
               state_d = S_RUN;
               a_d     = bus.a;
               // Subtract is folded into an add of ~b with carry-in forced high.
               b_d     = bus.op ? ~bus.b : bus.b;
               carry_d = bus.op ? 1'b1 : bus.cin;
               idx_d   = '0;
               acc_d   = '0;
            end
         end
         S_RUN: begin
            acc_d[w_base +: 8] = w_sum;
            carry_d            = w_co;
            idx_d              = idx_q + 1'b1;
            if (idx_q == IW'(WORDS - 1)) begin
               state_d  = S_DONE;
               result_d = acc_d;
               cout_d   = w_co;
`ifdef ADD_SEQ_OVF_EN
               ovf_d    = (a_q[W-1] == b_q[W-1]) && (acc_d[W-1] != a_q[W-1]);
`endif
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign bus.busy   = (state_q == S_RUN);
   assign bus.done   = (state_q == S_DONE);
   assign bus.result = result_q;
   assign bus.cout   = cout_q;
`ifdef ADD_SEQ_OVF_EN
   assign bus.ovf    = ovf_q;
`endif
endmodule

`default_nettype wire

// File: tb/tb_add_seq_ctrl.sv
// +--------------------------------------------------------------------------+
// | tb_add_seq_ctrl : randomized and directed bench for add_seq_ctrl.        |
// | Checks ovf when ADD_SEQ_OVF_EN is defined.  Rev 1.0                      |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_add_seq_ctrl;
   localparam int WORDS = 4;
   localparam int W     = 8 * WORDS;

   logic clk = 1'b0;
   logic rst_n;
   int   vectors    = 0;
   int   miscompares = 0;

   logic [W-1:0] prev_result;
   logic         prev_cout;
   logic         prev_ovf;

   always #5 clk = ~clk;

   add_seq_ctrl_if #(.WORDS(WORDS)) bus ();

   add_seq_ctrl #(.WORDS(WORDS)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic check_outputs(input string tag);
      check({tag, "_result"}, 64'(bus.result), 64'(prev_result));
      check({tag, "_cout"},   64'(bus.cout),   64'(prev_cout));
`ifdef ADD_SEQ_OVF_EN
      check({tag, "_ovf"},    64'(bus.ovf),    64'(prev_ovf));
`endif
   endtask

   // Called at a negedge; returns at the negedge on which done is observed.
   task automatic do_op(input logic op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin, input bit tog_cin, input bit mid_start);
      logic [W:0] sum;
      longint     s;
      longint     smax;
      int         busy_cnt;
      int         k;
      bit         seen;
      smax = (longint'(1) <<< (W-1));
      if (op) begin
         sum = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
         s   = longint'($signed(a)) - longint'($signed(b));
      end else begin
         sum = {1'b0, a} + {1'b0, b} + (W+1)'(cin);
         s   = longint'($signed(a)) + longint'($signed(b)) + longint'(cin);
      end
      bus.start = 1'b1;
      bus.op    = op;
      bus.a     = a;
      bus.b     = b;
      bus.cin   = cin;
      busy_cnt  = 0;
      seen      = 1'b0;
      for (k = 1; k <= WORDS + 4; k++) begin
         @(negedge clk);
         check("busy_done_excl", 64'(bus.busy & bus.done), 64'd0);
         if (bus.done) begin
            seen = 1'b1;
            break;
         end
         if (bus.busy) busy_cnt++;
         check("partial_hidden", 64'(bus.result), 64'(prev_result));
         if (k == 1) bus.start = 1'b0;
         if (mid_start && k == 2) begin
            bus.start = 1'b1;
            bus.a     = ~a;
            bus.b     = a ^ 32'h5A5A_A5A5;
            bus.op    = ~op;
         end
         if (mid_start && k == 3) bus.start = 1'b0;
         if (tog_cin) bus.cin = ~bus.cin;
      end
      check("done_seen",   64'(seen),     64'd1);
      check("latency",     64'(k - 1),    64'(WORDS));
      check("busy_cycles", 64'(busy_cnt), 64'(WORDS));
      prev_result = sum[W-1:0];
      prev_cout   = sum[W];
      prev_ovf    = (s >= smax) || (s < -smax);
      check_outputs("op");
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         check("idle_busy", 64'(bus.busy), 64'd0);
         check("idle_done", 64'(bus.done), 64'd0);
         check_outputs("hold");
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n     = 1'b0;
      bus.start = 1'b0;
      bus.op    = 1'b0;
      bus.a     = '0;
      bus.b     = '0;
      bus.cin   = 1'b0;
      prev_result = '0;
      prev_cout   = 1'b0;
      prev_ovf    = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_busy", 64'(bus.busy), 64'd0);
      check("rst_done", 64'(bus.done), 64'd0);
      check_outputs("rst");
      rst_n = 1'b1;

      // Directed cases
      do_op(1'b0, 32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 1'b0);
      check("basic_add", 64'(bus.result), 64'h0000_0100);
      idle(2);
      do_op(1'b0, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 1'b0);
      check("ripple_result", 64'(bus.result), 64'd0);
      check("ripple_cout",   64'(bus.cout),   64'd1);
      idle(1);
      do_op(1'b1, 32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 1'b0);
      check("sub_neg", 64'(bus.result), 64'hFFFF_FFFE);
      idle(1);
      do_op(1'b1, 32'h0000_0007, 32'h0000_0005, 1'b1, 1'b1, 1'b0);
      check("sub_pos", 64'(bus.result), 64'h0000_0002);
      check("sub_pos_cout", 64'(bus.cout), 64'd1);
      idle(1);
      do_op(1'b0, 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 1'b1);
      check("mid_start_ignored", 64'(bus.result), 64'h2345_6789);
      do_op(1'b0, 32'h0000_0010, 32'h0000_0020, 1'b1, 1'b0, 1'b0);
      check("back_to_back", 64'(bus.result), 64'h0000_0031);
      idle(1);
      do_op(1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0);
      do_op(1'b1, 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b0, 1'b0);
      do_op(1'b0, 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0, 1'b0);
      idle(1);

      // Asynchronous reset two cycles into RUN
      bus.start = 1'b1;
      bus.op    = 1'b0;
      bus.a     = 32'hDEAD_BEEF;
      bus.b     = 32'h0101_0101;
      @(negedge clk);
      bus.start = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      prev_result = '0;
      prev_cout   = 1'b0;
      prev_ovf    = 1'b0;
      check("midrst_busy", 64'(bus.busy), 64'd0);
      check("midrst_done", 64'(bus.done), 64'd0);
      check_outputs("midrst");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      idle(WORDS + 1);
      do_op(1'b0, 32'hDEAD_BEEF, 32'h0101_0101, 1'b0, 1'b0, 1'b0);
      check("after_rst", 64'(bus.result), 64'hDFAE_BFF0);

      // Randomized traffic
      for (int n = 0; n < 60; n++) begin
         logic [W-1:0] ra;
         logic [W-1:0] rb;
         ra = $urandom();
         rb = $urandom();
         if ($urandom_range(0, 3) == 0) rb = ra;
         if ($urandom_range(0, 5) == 0) ra = {1'b0, {(W-1){1'b1}}};
         do_op(1'($urandom_range(0, 1)), ra, rb, 1'($urandom_range(0, 1)),
               bit'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
         if ($urandom_range(0, 1) == 0) idle($urandom_range(1, 2));
      end
      idle(2);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

`default_nettype wire
